// File: rtl/uart_rx_ext.sv
// UART receiver with configurable data width, parity and stop bits.
// Each bit is a 3-sample majority vote; parity, framing and break errors are reported per frame.
module uart_rx_ext #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int unsigned B   = CLK_FREQ / BAUD_RATE;
    localparam int unsigned MID = B / 2;
    localparam int unsigned CW  = $clog2(B);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t state, state_n;

    logic                 rx_m, rx_s, rx_s_d;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 v0, v1;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit;
    logic                 any_one;
    logic                 stop_low;

    logic at_v0, at_v1, at_dec, at_last;
    logic last_data, last_stop;
    logic maj_now, maj_ahead;
    logic par_x, par_bad, frame_bad, is_break;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    assign at_v0     = (cnt == CW'(MID - 1));
    assign at_v1     = (cnt == CW'(MID));
    assign at_dec    = (cnt == CW'(MID + 1));
    assign at_last   = (cnt == CW'(B - 1));
    assign last_data = (bit_idx == 4'(DATA_BITS - 1));
    assign last_stop = (bit_idx == 4'(STOP_BITS - 1));

    // maj_ahead votes at cnt=MID using rx_m, which is exactly what rx_s holds at
    // MID+1; the final stop bit is thus decided a cycle early so rx_valid lands
    // in the MID+1 slot while the state still leaves at MID+1 as for every bit.
    assign maj_now   = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    assign maj_ahead = (v0 & rx_s) | (v0 & rx_m) | (rx_s & rx_m);

    assign par_x     = (^shreg) ^ pbit;
    assign par_bad   = (PARITY == 1) ? ~par_x : (PARITY == 2) ? par_x : 1'b0;
    assign frame_bad = stop_low | ~maj_ahead;
    assign is_break  = ~(any_one | maj_ahead);

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (rx_s_d && !rx_s) state_n = S_START;
            S_START: begin
                if (at_dec && maj_now) state_n = S_IDLE;
                else if (at_last)      state_n = S_DATA;
            end
            S_DATA: begin
                if (at_last && last_data)
                    state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY:     if (at_last) state_n = S_STOP;
            S_STOP: begin
                if (at_dec && last_stop)
                    state_n = break_det ? S_BREAK_WAIT : S_IDLE;
            end
            S_BREAK_WAIT: if (rx_s) state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            v0         <= 1'b1;
            v1         <= 1'b1;
            shreg      <= '0;
            pbit       <= 1'b0;
            any_one    <= 1'b0;
            stop_low   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (at_v0) v0 <= rx_s;
            if (at_v1) v1 <= rx_s;

            case (state)
                S_IDLE, S_BREAK_WAIT: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    any_one  <= 1'b0;
                    stop_low <= 1'b0;
                end
                default: cnt <= at_last ? '0 : cnt + CW'(1);
            endcase

            case (state)
                S_DATA: begin
                    if (at_dec) begin
                        shreg   <= {maj_now, shreg[DATA_BITS-1:1]};
                        any_one <= any_one | maj_now;
                    end
                    if (at_last) bit_idx <= last_data ? '0 : bit_idx + 4'd1;
                end
                S_PARITY: begin
                    if (at_dec) begin
                        pbit    <= maj_now;
                        any_one <= any_one | maj_now;
                    end
                end
                S_STOP: begin
                    if (at_dec && !last_stop) begin
                        any_one  <= any_one | maj_now;
                        stop_low <= stop_low | ~maj_now;
                    end
                    if (at_last) bit_idx <= bit_idx + 4'd1;
                    if (at_v1 && last_stop) begin
                        rx_data    <= shreg;
                        parity_err <= par_bad;
                        frame_err  <= frame_bad;
                        break_det  <= is_break;
                        rx_valid   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: four configurations share one serial line,
// each received frame is compared with a frame-level reference model.
module tb_uart_rx_ext;
    localparam int B0 = 434;
    localparam int BS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] d0_data, d1_data, d2_data;
    logic [8:0] d3_data;
    logic [3:0] vld, pe, fe, bd, by;
    logic [8:0] dout [4];

    assign dout[0] = {1'b0, d0_data};
    assign dout[1] = {1'b0, d1_data};
    assign dout[2] = {1'b0, d2_data};
    assign dout[3] = d3_data;

    uart_rx_ext u_def (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(d0_data), .rx_valid(vld[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]), .busy(by[0])
    );
    uart_rx_ext #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY(2)) u_par (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(d1_data), .rx_valid(vld[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]), .busy(by[1])
    );
    uart_rx_ext #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(d2_data), .rx_valid(vld[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]), .busy(by[2])
    );
    uart_rx_ext #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(9)) u_9b (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(d3_data), .rx_valid(vld[3]),
        .parity_err(pe[3]), .frame_err(fe[3]), .break_det(bd[3]), .busy(by[3])
    );

    typedef struct {
        int          dut;
        int unsigned cyc;
        logic [8:0]  data;
        logic        pe;
        logic        fe;
        logic        bd;
    } rec_t;

    rec_t        vq[$];
    int unsigned rise [4];
    int unsigned fall [4];
    logic [3:0]  pby = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (vld[k] === 1'b1) begin
                rec_t r;
                r.dut = k; r.cyc = cyc; r.data = dout[k];
                r.pe = pe[k]; r.fe = fe[k]; r.bd = bd[k];
                vq.push_back(r);
            end
            if (by[k] && !pby[k]) rise[k] = cyc;
            if (!by[k] && pby[k]) fall[k] = cyc;
        end
        pby = by;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    function automatic int count_valid(input int k);
        int n = 0;
        foreach (vq[i]) if (vq[i].dut == k) n++;
        return n;
    endfunction

    // Frame-level model: expected word and flags from the bits placed on the line.
    function automatic void ref_frame(input int dbits, input int par, input int sbits,
                                      input logic [8:0] word, input logic pbit,
                                      input logic [1:0] stops, output logic [8:0] ed,
                                      output logic epe, output logic efe, output logic ebd);
        int ones;
        bit zero_all;
        ed = '0;
        for (int i = 0; i < dbits; i++) ed[i] = word[i];
        ones = $countones(ed) + ((par != 0 && pbit) ? 1 : 0);
        epe = (par == 1) ? (ones % 2 == 0) : (par == 2) ? (ones % 2 == 1) : 1'b0;
        zero_all = (ed == 0) && !(par != 0 && pbit);
        efe = 1'b0;
        for (int i = 0; i < sbits; i++) begin
            if (!stops[i]) efe = 1'b1;
            else           zero_all = 1'b0;
        end
        ebd = efe && zero_all;
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int bclk, input int dbits, input int par, input int sbits,
                              input logic [8:0] word, input logic pbit, input logic [1:0] stops,
                              input int spike_slot, input int rst_slot);
        logic lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < dbits; i++) lv.push_back(word[i]);
        if (par != 0) lv.push_back(pbit);
        for (int i = 0; i < sbits; i++) lv.push_back(stops[i]);
        foreach (lv[s]) begin
            for (int j = 0; j < bclk; j++) begin
                rx = (s == spike_slot && j == bclk / 2 + 1) ? ~lv[s] : lv[s];
                if (s == rst_slot) rst = (j >= bclk / 2 && j < bclk / 2 + 3);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_valid(input int k, input int budget, output bit ok, output rec_t r);
        ok = 1'b0;
        for (int i = 0; i <= budget && !ok; i++) begin
            for (int j = 0; j < vq.size(); j++) begin
                if (!ok && vq[j].dut == k) begin
                    r = vq[j];
                    vq.delete(j);
                    ok = 1'b1;
                end
            end
            if (!ok && i < budget) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_frame(input string name, input int k, input int bclk, input int dbits,
                              input int par, input int sbits, input logic [8:0] word,
                              input logic pbit, input logic [1:0] stops,
                              input int spike_slot, input int gap);
        logic [8:0]  ed;
        logic        epe, efe, ebd;
        rec_t        r;
        bit          ok;
        int unsigned lat;
        send_frame(bclk, dbits, par, sbits, word, pbit, stops, spike_slot, -1);
        ref_frame(dbits, par, sbits, word, pbit, stops, ed, epe, efe, ebd);
        wait_valid(k, 8, ok, r);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_valid: got no rx_valid expected one pulse", name);
        end else begin
            lat = (dbits + ((par != 0) ? 1 : 0) + sbits) * bclk + bclk / 2 + 1;
            n_chk++;
            if (r.data !== ed) begin
                n_fail++; $display("FAIL %s_data: got %h expected %h", name, r.data, ed);
            end
            n_chk++;
            if (r.pe !== epe) begin
                n_fail++; $display("FAIL %s_parity_err: got %b expected %b", name, r.pe, epe);
            end
            n_chk++;
            if (r.fe !== efe) begin
                n_fail++; $display("FAIL %s_frame_err: got %b expected %b", name, r.fe, efe);
            end
            n_chk++;
            if (r.bd !== ebd) begin
                n_fail++; $display("FAIL %s_break_det: got %b expected %b", name, r.bd, ebd);
            end
            n_chk++;
            if (r.cyc - rise[k] !== lat) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d expected %0d", name, r.cyc - rise[k], lat);
            end
        end
        idle(gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        n_chk++;
        if (d0_data !== 8'h00 || vld[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_data_valid: got %h/%b expected 00/0", d0_data, vld[0]);
        end
        n_chk++;
        if ({pe[0], fe[0], bd[0]} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {pe[0], fe[0], bd[0]});
        end
        rst = 1'b0;
        idle(8);
        n_chk++;
        if (by !== 4'b0000) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0000", by);
        end
    endtask

    task automatic test_8n1();
        vq.delete();
        test_frame("a5", 0, B0, 8, 0, 1, 9'h0A5, 1'b0, 2'b01, -1, 4);
        n_chk++;
        if (fall[0] - rise[0] !== 4125) begin
            n_fail++; $display("FAIL a5_busy_low: got %0d expected 4125", fall[0] - rise[0]);
        end
        for (int i = 0; i < 3; i++)
            test_frame("rand8n1", 0, B0, 8, 0, 1, 9'($urandom_range(0, 255)), 1'b0, 2'b01, -1, 0);
        idle(20);
    endtask

    task automatic test_glitch();
        vq.delete();
        rx = 1'b0;
        repeat (100) begin @(posedge clk); #1; end
        idle(600);
        n_chk++;
        if (count_valid(0) !== 0) begin
            n_fail++; $display("FAIL glitch_no_valid: got %0d expected 0", count_valid(0));
        end
        n_chk++;
        if (fall[0] - rise[0] !== 219) begin
            n_fail++; $display("FAIL glitch_busy: got %0d expected 219", fall[0] - rise[0]);
        end
        test_frame("spike", 0, B0, 8, 0, 1, 9'($urandom_range(0, 255)), 1'b0, 2'b01, 4, 20);
    endtask

    task automatic test_break();
        rec_t r;
        bit   ok;
        vq.delete();
        rx = 1'b0;
        repeat (20 * B0) begin @(posedge clk); #1; end
        n_chk++;
        if (by[0] !== 1'b1) begin
            n_fail++; $display("FAIL break_busy_held: got %b expected 1", by[0]);
        end
        wait_valid(0, 0, ok, r);
        n_chk++;
        if (!ok) begin
            n_fail++; $display("FAIL break_valid: got none expected one");
        end else begin
            n_chk++;
            if ({r.data, r.pe, r.fe, r.bd} !== {9'h000, 1'b0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL break_word: got data=%h pe=%b fe=%b bd=%b expected 000/0/1/1",
                         r.data, r.pe, r.fe, r.bd);
            end
        end
        rx = 1'b1;
        idle(6);
        n_chk++;
        if (by[0] !== 1'b0) begin
            n_fail++; $display("FAIL break_busy_release: got %b expected 0", by[0]);
        end
        idle(500);
        n_chk++;
        if (count_valid(0) !== 0) begin
            n_fail++; $display("FAIL break_second_valid: got %0d expected 0", count_valid(0));
        end
    endtask

    task automatic test_reset_mid();
        vq.delete();
        send_frame(B0, 8, 0, 1, 9'h0F0, 1'b0, 2'b01, -1, 5);
        idle(20);
        n_chk++;
        if (count_valid(0) !== 0) begin
            n_fail++; $display("FAIL rstmid_valid: got %0d expected 0", count_valid(0));
        end
        n_chk++;
        if ({d0_data, pe[0], fe[0], bd[0], by[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got data=%h pe=%b fe=%b bd=%b busy=%b expected all 0",
                     d0_data, pe[0], fe[0], bd[0], by[0]);
        end
        test_frame("after_rst", 0, B0, 8, 0, 1, 9'h03C, 1'b0, 2'b01, -1, 20);
    endtask

    task automatic test_parity();
        vq.delete();
        test_frame("par_ok", 1, BS, 8, 2, 1, 9'h037, 1'b1, 2'b01, -1, 0);
        test_frame("par_bad", 1, BS, 8, 2, 1, 9'h037, 1'b0, 2'b01, -1, 0);
        for (int i = 0; i < 8; i++)
            test_frame("par_rand", 1, BS, 8, 2, 1, 9'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), 2'b01, -1, 0);
        idle(2 * BS);
    endtask

    task automatic test_back_to_back();
        vq.delete();
        test_frame("stop2_55", 2, BS, 8, 0, 2, 9'h055, 1'b0, 2'b11, -1, 0);
        test_frame("stop2_aa", 2, BS, 8, 0, 2, 9'h0AA, 1'b0, 2'b11, -1, 0);
        test_frame("stop2_err", 2, BS, 8, 0, 2, 9'h00F, 1'b0, 2'b01, -1, 2 * BS);
        for (int i = 0; i < 6; i++)
            test_frame("stop2_rand", 2, BS, 8, 0, 2, 9'($urandom_range(0, 255)), 1'b0,
                       2'($urandom_range(0, 3)), -1, 2 * BS);
    endtask

    task automatic test_9bit();
        vq.delete();
        test_frame("d9_1ff", 3, BS, 9, 0, 1, 9'h1FF, 1'b0, 2'b01, -1, 0);
        for (int i = 0; i < 6; i++)
            test_frame("d9_rand", 3, BS, 9, 0, 1, 9'($urandom_range(0, 511)), 1'b0, 2'b01, -1, 0);
        idle(2 * BS);
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_8n1();
        test_glitch();
        test_break();
        test_reset_mid();
        idle(64);
        test_parity();
        test_back_to_back();
        test_9bit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
